// File: rtl/approx_mac_accum.sv
// Frame accumulator for approximate-multiplier products: sums FRAME_LEN products with saturation.
// Result valid 1 cycle after the last transfer; holds until out_ready, input stalls freely on in_valid.
module approx_mac_accum #(
   parameter int FRAME_LEN = 8,
   parameter int ACC_W     = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      product,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             overflow,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

   state_t           state, state_nxt;
   logic [ACC_W-1:0] acc, acc_nxt;
   logic [7:0]       count, count_nxt;
   logic             ovf, ovf_nxt;
   logic [ACC_W:0]   sum;
   logic             sat;

   // One spare bit catches the carry that triggers saturation.
   assign sum = {1'b0, acc} + {{(ACC_W + 1 - 16){1'b0}}, product};
   assign sat = sum[ACC_W];

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      count_nxt = count;
      ovf_nxt   = ovf;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = ACCUM;
               acc_nxt   = '0;
               count_nxt = '0;
               ovf_nxt   = 1'b0;
            end
         end
         ACCUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) begin
               acc_nxt   = sat ? '1 : sum[ACC_W-1:0];
               ovf_nxt   = ovf | sat;
               count_nxt = count + 8'd1;
               if (count == LAST_IDX) begin
                  state_nxt = HOLD;
               end
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Cancel wins over everything; the register values stay as they were.
      if (abort) begin
         state_nxt = IDLE;
         acc_nxt   = acc;
         count_nxt = count;
         ovf_nxt   = ovf;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         count <= count_nxt;
         ovf   <= ovf_nxt;
      end
   end

   assign acc_out  = acc;
   assign overflow = ovf;

endmodule
